// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one block-RAM port; grant is combinational, memory inputs registered, read data back RD_LATENCY+2 cycles after gnt.
// Backpressure: a requester holds req/we/addr/wdata until its one-cycle gnt; one access per cycle, fully pipelined.
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int PRIO_MODE  = 0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One tag stage per cycle from issue until mem_rdata is valid.
  localparam int STAGES = RD_LATENCY + 1;

  logic              prefer_r1;
  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [STAGES-1:0] tag_vld;
  logic [STAGES-1:0] tag_own;
  logic              ret_r0;
  logic              ret_r1;

  // Grant selection; suppressed while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (r0_req && r1_req) begin
        if (PRIO_MODE != 0) begin
          gnt0 = 1'b1;
        end else if (prefer_r1) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else if (r0_req) begin
        gnt0 = 1'b1;
      end else if (r1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? r1_we    : r0_we;
    sel_addr  = gnt1 ? r1_addr  : r0_addr;
    sel_wdata = gnt1 ? r1_wdata : r0_wdata;
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  // Round-robin pointer moves only when someone is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_r1 <= 1'b0;
    end else if (gnt0) begin
      prefer_r1 <= 1'b1;
    end else if (gnt1) begin
      prefer_r1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= any_gnt & sel_we;
      if (any_gnt) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

  // Tag pipe: stage 0 lines up with the issue cycle, last stage with mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld <= {tag_vld[STAGES-2:0], any_gnt & ~sel_we};
      tag_own <= {tag_own[STAGES-2:0], gnt1};
    end
  end

  always_comb begin
    ret_r0 = tag_vld[STAGES-1] & ~tag_own[STAGES-1];
    ret_r1 = tag_vld[STAGES-1] &  tag_own[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= ret_r0;
      r1_rvalid <= ret_r1;
      if (ret_r0) begin
        r0_rdata <= mem_rdata;
      end
      if (ret_r1) begin
        r1_rdata <= mem_rdata;
      end
    end
  end

endmodule
